// File: rtl/l2_write_buffer_pkg.sv
// ----------------------------------------------------------------------------
// l2_write_buffer_pkg
// Shared types and constants for the L2 line write buffer.
//   wb_state_t       : controller states (idle, write ack, forward, memory read, drain)
//   LINE_OFFSET_BITS : byte-offset bits within a cache line, ignored for matching
//   wb_entry_t       : one buffered line {valid, line_addr, data} at default widths
// Optional feature macro used by the top level: WB_FORWARD_EN.
// ----------------------------------------------------------------------------
package l2_write_buffer_pkg;

    localparam int unsigned LINE_OFFSET_BITS = 5;
    localparam int unsigned WB_ADDR_WIDTH    = 16;
    localparam int unsigned WB_LINE_WIDTH    = 256;

    typedef enum logic [2:0] {
        StIdle,
        StWack,
        StFwd,
        StMread,
        StDrain
    } wb_state_t;

    typedef struct packed {
        logic                                      valid;
        logic [WB_ADDR_WIDTH-LINE_OFFSET_BITS-1:0] line_addr;
        logic [WB_LINE_WIDTH-1:0]                  data;
    } wb_entry_t;

endpackage

// File: rtl/l2_write_buffer_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Circular line store for the write buffer with a parallel line-address lookup.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   lookup_tag_i    : line address being looked up (also the tag stored on write)
//   wr_en_i         : store wr_data_i; overwrites a matching entry, else enqueues
//   wr_data_i       : line data to store
//   pop_i           : retire the head entry
//   hit_o           : lookup_tag_i matches a valid entry
//   hit_data_o      : data of the youngest matching entry
//   head_tag_o      : line address of the head entry
//   head_data_o     : data of the head entry
//   full_o, empty_o : occupancy flags
// ----------------------------------------------------------------------------
module wb_fifo #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned TAG_WIDTH  = 11,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TAG_WIDTH-1:0]  lookup_tag_i,
    input  logic                  wr_en_i,
    input  logic [LINE_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic                  hit_o,
    output logic [LINE_WIDTH-1:0] hit_data_o,
    output logic [TAG_WIDTH-1:0]  head_tag_o,
    output logic [LINE_WIDTH-1:0] head_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q   [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_d   [DEPTH];
    logic [LINE_WIDTH-1:0] data_q  [DEPTH];
    logic [LINE_WIDTH-1:0] data_d  [DEPTH];
    logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [PtrW-1:0]       hit_idx, scan_idx;

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_o    = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PtrW'(k);
            if (valid_q[scan_idx] && (tag_q[scan_idx] == lookup_tag_i)) begin
                hit_o   = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (wr_en_i) begin
            if (hit_o) begin
                // Coalesce: same line already buffered, occupancy unchanged.
                data_d[hit_idx] = wr_data_i;
            end else begin
                valid_d[tail_q] = 1'b1;
                tag_d[tail_q]   = lookup_tag_i;
                data_d[tail_q]  = wr_data_i;
                tail_d          = tail_q + 1'b1;
                count_d         = count_q + 1'b1;
            end
        end else if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            count_d         = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_data_o  = data_q[hit_idx];
    assign head_tag_o  = tag_q[head_q];
    assign head_data_o = data_q[head_q];
    assign full_o      = (count_q == CntW'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/l2_write_buffer.sv
// ----------------------------------------------------------------------------
// l2_write_buffer
// Line-granular write buffer between the L2 physical-memory port and memory.
// Writebacks are absorbed in one cycle; refill reads go ahead of pending
// writebacks; buffered lines drain to memory when the port is otherwise idle.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   l2_pmem_read      : L2 line read, held until l2_pmem_resp
//   l2_pmem_write     : L2 line writeback, held until l2_pmem_resp
//   l2_pmem_address   : L2 request byte address
//   l2_pmem_wdata     : writeback line
//   l2_pmem_rdata     : line returned to L2
//   l2_pmem_resp      : one-cycle completion pulse to L2
//   mem_read/mem_write: memory requests, held until mem_resp
//   mem_address       : memory byte address
//   mem_wdata/rdata   : memory write/read line
//   mem_resp          : memory completion pulse
// Build option: define WB_FORWARD_EN to serve read hits straight from the
// buffer; otherwise matching lines are drained first and the read goes to memory.
// ----------------------------------------------------------------------------
module l2_write_buffer
    import l2_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned LINE_WIDTH  = 256,
    parameter int unsigned OFFSET_BITS = LINE_OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l2_pmem_read,
    input  logic                  l2_pmem_write,
    input  logic [ADDR_WIDTH-1:0] l2_pmem_address,
    input  logic [LINE_WIDTH-1:0] l2_pmem_wdata,
    output logic [LINE_WIDTH-1:0] l2_pmem_rdata,
    output logic                  l2_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int unsigned TagW = ADDR_WIDTH - OFFSET_BITS;

    wb_state_t             state_q, state_d;
    logic                  fifo_wr, fifo_pop;
    logic                  hit, full, empty;
    logic [LINE_WIDTH-1:0] hit_data, head_data;
    logic [TagW-1:0]       head_tag;

    wb_fifo #(
        .DEPTH      (DEPTH),
        .TAG_WIDTH  (TagW),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .lookup_tag_i (l2_pmem_address[ADDR_WIDTH-1:OFFSET_BITS]),
        .wr_en_i      (fifo_wr),
        .wr_data_i    (l2_pmem_wdata),
        .pop_i        (fifo_pop),
        .hit_o        (hit),
        .hit_data_o   (hit_data),
        .head_tag_o   (head_tag),
        .head_data_o  (head_data),
        .full_o       (full),
        .empty_o      (empty)
    );

`ifndef WB_FORWARD_EN
    logic unused_hit_data;
    assign unused_hit_data = ^hit_data;
`endif

    always_comb begin
        state_d       = state_q;
        fifo_wr       = 1'b0;
        fifo_pop      = 1'b0;
        l2_pmem_rdata = '0;
        l2_pmem_resp  = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_wdata     = '0;
        unique case (state_q)
            StIdle: begin
                // Read beats write beats background drain.
                if (l2_pmem_read) begin
`ifdef WB_FORWARD_EN
                    state_d = hit ? StFwd : StMread;
`else
                    // Stale memory copy: push matching lines out before reading.
                    state_d = hit ? StDrain : StMread;
`endif
                end else if (l2_pmem_write) begin
                    if (!full) begin
                        fifo_wr = 1'b1;
                        state_d = StWack;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (!empty) begin
                    state_d = StDrain;
                end
            end
            StWack: begin
                l2_pmem_resp = 1'b1;
                state_d      = StIdle;
            end
            StFwd: begin
`ifdef WB_FORWARD_EN
                l2_pmem_rdata = hit_data;
                l2_pmem_resp  = 1'b1;
`endif
                state_d = StIdle;
            end
            StMread: begin
                mem_read      = 1'b1;
                mem_address   = l2_pmem_address;
                l2_pmem_rdata = mem_rdata;
                l2_pmem_resp  = mem_resp;
                if (mem_resp) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                // FIFO is frozen in this state, so these stay stable until mem_resp.
                mem_write   = 1'b1;
                mem_address = {head_tag, {OFFSET_BITS{1'b0}}};
                mem_wdata   = head_data;
                if (mem_resp) begin
                    fifo_pop = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // L2 issues one request at a time.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(l2_pmem_read && l2_pmem_write));
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
module tb_l2_write_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         l2_pmem_read, l2_pmem_write;
    logic [15:0]  l2_pmem_address;
    logic [255:0] l2_pmem_wdata, l2_pmem_rdata;
    logic         l2_pmem_resp;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_resp;

    always #5 clk = ~clk;

    l2_write_buffer #(
        .DEPTH       (2),
        .ADDR_WIDTH  (16),
        .LINE_WIDTH  (256),
        .OFFSET_BITS (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .l2_pmem_read    (l2_pmem_read),
        .l2_pmem_write   (l2_pmem_write),
        .l2_pmem_address (l2_pmem_address),
        .l2_pmem_wdata   (l2_pmem_wdata),
        .l2_pmem_rdata   (l2_pmem_rdata),
        .l2_pmem_resp    (l2_pmem_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    typedef struct {
        bit           wr;
        logic [15:0]  addr;
        logic [255:0] data;
        int           cyc;
    } ev_t;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           viol     = 0;
    int           cyc      = 0;
    int           mem_lat  = 1;
    bit           mem_stall = 1'b0;
    logic [255:0] mem_arr [int];   // physical memory contents
    logic [255:0] golden  [int];   // latest line value L2 has written
    ev_t          ev_q [$];
    int           last_resp_cyc;
    logic [255:0] last_mem_rdata;

    function automatic logic [255:0] mem_value(input int line);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(line * 7 + i) ^ 16'h5A00;
        return v;
    endfunction

    function automatic logic [255:0] mem_get(input int line);
        return mem_arr.exists(line) ? mem_arr[line] : mem_value(line);
    endfunction

    function automatic logic [255:0] exp_line(input int line);
        return golden.exists(line) ? golden[line] : mem_value(line);
    endfunction

    function automatic int n_ev(input int from, input bit wr);
        int n = 0;
        for (int i = from; i < ev_q.size(); i++) if (ev_q[i].wr == wr) n++;
        return n;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: answers a held request after mem_lat cycles unless stalled.
    initial begin
        int  busy;
        ev_t e;
        busy      = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            mem_resp = 1'b0;
            if (rst || mem_stall || !(mem_read || mem_write)) begin
                busy = 0;
            end else begin
                busy++;
                if (busy >= mem_lat) begin
                    busy   = 0;
                    e.wr   = mem_write;
                    e.addr = mem_address;
                    e.cyc  = cyc;
                    if (mem_write) begin
                        mem_arr[int'(mem_address >> 5)] = mem_wdata;
                        e.data = mem_wdata;
                    end else begin
                        mem_rdata = mem_get(int'(mem_address >> 5));
                        e.data = mem_rdata;
                    end
                    ev_q.push_back(e);
                    mem_resp = 1'b1;
                end
            end
        end
    end

    // Protocol monitor: exclusive memory requests, no orphan L2 resp, drain held stable.
    initial begin
        logic         prev_w, prev_resp;
        logic [15:0]  prev_a;
        logic [255:0] prev_d;
        prev_w = 1'b0; prev_resp = 1'b0; prev_a = '0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_read && mem_write) viol++;
                if (l2_pmem_resp && !l2_pmem_read && !l2_pmem_write) viol++;
                if (prev_w && !prev_resp &&
                    (!mem_write || mem_address !== prev_a || mem_wdata !== prev_d)) viol++;
            end
            prev_w    = mem_write && !rst;
            prev_resp = mem_resp;
            prev_a    = mem_address;
            prev_d    = mem_wdata;
        end
    end

    // Issue one L2 request and hold it until resp; returns cycles to resp.
    task automatic l2_req(input bit wr, input logic [15:0] a, input logic [255:0] d,
                          input int bound, output int lat, output logic [255:0] rd);
        bit got = 1'b0;
        l2_pmem_read    = !wr;
        l2_pmem_write   = wr;
        l2_pmem_address = a;
        l2_pmem_wdata   = d;
        lat = 0;
        rd  = '0;
        while (!got && lat < bound) begin
            @(negedge clk);
            lat++;
            if (l2_pmem_resp) begin
                got            = 1'b1;
                rd             = l2_pmem_rdata;
                last_mem_rdata = mem_rdata;
                last_resp_cyc  = cyc;
            end
        end
        chk("l2_resp_seen", got, 1);
        @(posedge clk);
        #1;
        l2_pmem_read  = 1'b0;
        l2_pmem_write = 1'b0;
    endtask

    task automatic l2_write(input logic [15:0] a, input logic [255:0] d, output int lat);
        logic [255:0] rd;
        l2_req(1'b1, a, d, 40, lat, rd);
        golden[int'(a >> 5)] = d;
    endtask

    task automatic l2_read(input logic [15:0] a, output int lat, output logic [255:0] rd);
        l2_req(1'b0, a, '0, 60, lat, rd);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!(dut.u_fifo.count_q == 0 && !mem_write && !mem_read) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < 300, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           lat, mark, n, rc;
        bit           seen, got, wr;
        logic [255:0] rd, da, db, d1, d2, d3;
        logic [15:0]  a;
        int           lines [6] = '{8, 9, 16, 146, 512, 2047};
        int           ln;

        rst = 1'b1;
        l2_pmem_read = 1'b0; l2_pmem_write = 1'b0;
        l2_pmem_address = '0; l2_pmem_wdata = '0;
        #1;
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_l2_resp", l2_pmem_resp, 0);
        chk("rst_l2_rdata", l2_pmem_rdata, 0);
        chk("rst_count", dut.u_fifo.count_q, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write then background drain.
        mem_lat = 2;
        da = rand_line();
        l2_write(16'h1240, da, lat);
        chk("t1_wr_lat", lat, 2);
        n = 0;
        while (!mem_write && n < 3) begin @(negedge clk); n++; end
        chk("t1_drain_wr", mem_write, 1);
        chk("t1_drain_addr", mem_address, 16'h1240);
        chk("t1_drain_data", mem_wdata, da);
        wait_empty("t1_empty");
        chk("t1_count", dut.u_fifo.count_q, 0);
        chk("t1_mem", mem_get(146), da);

        // Read hitting a buffered line.
        mark = ev_q.size();
        da = rand_line();
        l2_write(16'h1240, da, lat);
        l2_read(16'h1250, lat, rd);
        chk("t2_rd_data", rd, da);
`ifdef WB_FORWARD_EN
        chk("t2_fwd_lat", lat, 2);
        wait_empty("t2_empty");
        chk("t2_no_mread", n_ev(mark, 1'b0), 0);
        chk("t2_one_wr", n_ev(mark, 1'b1), 1);
`else
        wait_empty("t2_empty");
        chk("t2_ev_n", ev_q.size() - mark, 2);
        chk("t2_ev0_wr", ev_q[mark].wr, 1);
        chk("t2_ev0_addr", ev_q[mark].addr, 16'h1240);
        chk("t2_ev1_rd", ev_q[mark+1].wr, 0);
        chk("t2_ev1_addr", ev_q[mark+1].addr, 16'h1250);
`endif

        // Full buffer: third write waits for a drain.
        mem_lat = 1;
        mem_stall = 1'b1;
        d1 = rand_line(); d2 = rand_line(); d3 = rand_line();
        l2_write(16'h0100, d1, lat);
        l2_write(16'h0200, d2, lat);
        chk("t3_full_count", dut.u_fifo.count_q, 2);
        mark = ev_q.size();
        l2_pmem_write = 1'b1; l2_pmem_address = 16'h0300; l2_pmem_wdata = d3;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); if (l2_pmem_resp) seen = 1'b1; end
        chk("t3_no_resp", seen, 0);
        chk("t3_drain_wr", mem_write, 1);
        chk("t3_drain_addr", mem_address, 16'h0100);
        chk("t3_drain_data", mem_wdata, d1);
        mem_stall = 1'b0;
        got = 1'b0; n = 0; rc = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (l2_pmem_resp) begin got = 1'b1; rc = cyc; end
        end
        chk("t3_resp_seen", got, 1);
        @(posedge clk);
        #1;
        l2_pmem_write = 1'b0;
        golden[24] = d3;
        chk("t3_ev_present", ev_q.size() > mark, 1);
        chk("t3_resp_gap", rc - ev_q[mark].cyc, 2);
        wait_empty("t3_empty");
        chk("t3_nwr", n_ev(mark, 1'b1), 3);

        // Read miss goes to memory ahead of the pending writeback.
        mem_lat = 3;
        mark = ev_q.size();
        db = rand_line();
        l2_write(16'h0100, db, lat);
        l2_read(16'h4000, lat, rd);
        chk("t4_rd_data", rd, exp_line(512));
        chk("t4_rd_eq_mem", rd, last_mem_rdata);
        wait_empty("t4_empty");
        chk("t4_ev_n", ev_q.size() - mark, 2);
        chk("t4_ev0_rd", ev_q[mark].wr, 0);
        chk("t4_ev0_addr", ev_q[mark].addr, 16'h4000);
        chk("t4_ev1_wr", ev_q[mark+1].wr, 1);
        chk("t4_ev1_addr", ev_q[mark+1].addr, 16'h0100);

        // Coalescing writes to one line.
        mem_lat = 2;
        mark = ev_q.size();
        da = rand_line(); db = rand_line();
        l2_write(16'h0100, da, lat);
        l2_write(16'h0100, db, lat);
        chk("t5_count", dut.u_fifo.count_q, 1);
        wait_empty("t5_empty");
        chk("t5_nwr", n_ev(mark, 1'b1), 1);
        chk("t5_data", ev_q[mark].data, db);

        // Reset in the middle of a drain.
        mem_stall = 1'b1;
        l2_req(1'b1, 16'h0700, rand_line(), 10, lat, rd);
        n = 0;
        while (!mem_write && n < 5) begin @(negedge clk); n++; end
        chk("t6_drain_started", mem_write, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_mem_write", mem_write, 0);
        chk("t6_mem_address", mem_address, 0);
        chk("t6_mem_wdata", mem_wdata, 0);
        chk("t6_mem_read", mem_read, 0);
        chk("t6_l2_resp", l2_pmem_resp, 0);
        chk("t6_count", dut.u_fifo.count_q, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_stall = 1'b0;
        mark = ev_q.size();
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_wr", ev_q.size() - mark, 0);
        chk("t6_line_lost", mem_arr.exists(56), 0);

        // Randomized traffic against the line-level reference.
        for (int i = 0; i < 300; i++) begin
            wr      = 1'($urandom_range(0, 1));
            ln      = lines[$urandom_range(0, 5)];
            a       = {ln[10:0], 5'($urandom_range(0, 31))};
            mem_lat = $urandom_range(1, 3);
            if (wr) begin
                l2_write(a, rand_line(), lat);
            end else begin
                l2_read(a, lat, rd);
                chk("rand_rd", rd, exp_line(ln));
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        wait_empty("final_empty");
        foreach (golden[k]) chk("final_mem", mem_get(k), golden[k]);
        chk("protocol_viol", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
